// File: rtl/ddr_cmd_pkg.sv
// Shared encodings for the DDR4 PHY command bus: command codes, per-bank
// state, receiver error codes and the transaction record layout.
package ddr_cmd_pkg;

  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_ZQ  = 3'b110;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVATING  = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ACT_N     = 3'd1;
  localparam logic [2:0] ERR_ACT_BUSY  = 3'd2;
  localparam logic [2:0] ERR_NOT_OPEN  = 3'd3;
  localparam logic [2:0] ERR_PRE_TRCD  = 3'd4;
  localparam logic [2:0] ERR_ALL_BUSY  = 3'd5;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd6;

  // Transaction layout for the default geometry (row 16, bank 3, col 10).
  // The receiver carries the same {write, addr} packing as a flat vector so
  // that other geometries remain possible.
  localparam int TXN_ADDR_W = 16 + 3 + 10;

  typedef struct packed {
    logic                  write;
    logic [TXN_ADDR_W-1:0] addr;
  } txn_t;

endpackage

// File: rtl/rx_txn_fifo.sv
// Two-entry synchronous valid/ready buffer for received transactions.
// A push while full is accepted only when the head is popped on the same edge.
module rx_txn_fifo #(
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             pop;
  logic             push_ok;

  assign valid_o = (count_q != 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop     = valid_o && ready_i;
  assign push_ok = push_i && (!full_o || pop);

  // Storage, pointers and occupancy; reset clears storage so the head reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr_cmd_receiver.sv
// Memory-side DDR4 command receiver: samples chip-selected commands, tracks
// per-bank open row and tRCD/tRP timing, rebuilds {row, bank, col} for each
// RD/WR into a 2-entry buffer, and reports protocol violations.
module ddr_cmd_receiver
  import ddr_cmd_pkg::*;
#(
  parameter int BANK_WIDTH = 3,
  parameter int ROW_WIDTH  = 16,
  parameter int COL_WIDTH  = 10,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  localparam int ADDR_WIDTH = ROW_WIDTH + BANK_WIDTH + COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            phy_cmd,
  input  logic [15:0]           phy_addr,
  input  logic [1:0]            phy_bank,
  input  logic                  phy_bg,
  input  logic                  phy_act_n,
  input  logic                  phy_cs_n,
  output logic                  txn_valid,
  input  logic                  txn_ready,
  output logic                  txn_write,
  output logic [ADDR_WIDTH-1:0] txn_addr,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [15:0]           ref_count
);

  localparam int NB   = 2 ** BANK_WIDTH;
  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [BANK_WIDTH-1:0] cmd_bank;
  logic                  sampled;
  logic                  act_mis;
  logic                  cmd_ok;
  logic                  err_hit;
  logic [2:0]            err_sel;
  logic                  push;
  logic                  ref_hit;
  logic [NB-1:0]         act_go;
  logic [NB-1:0]         pre_go;

  logic [NB-1:0]         bank_idle;
  logic [NB-1:0]         bank_rw_ok;
  logic [NB-1:0]         bank_activating;
  logic [ROW_WIDTH-1:0]  open_row [NB];

  logic                  fifo_full;
  logic                  fifo_pop;
  logic [ADDR_WIDTH:0]   push_data;
  logic [ADDR_WIDTH:0]   head_data;

  logic                  err_valid_q;
  logic [2:0]            err_code_q;
  logic [15:0]           ref_count_q;

  assign cmd_bank = BANK_WIDTH'({phy_bg, phy_bank});
  assign fifo_pop = txn_valid && txn_ready;

  // Per-bank state machines: open row plus a shared tRCD/tRP down-counter.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    bank_state_e          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;

    assign bank_activating[b] = (state_q == BANK_ACTIVATING);
    assign bank_rw_ok[b]      = (state_q == BANK_ACTIVE) ||
                                (state_q == BANK_ACTIVATING && timer_q == '0);
    assign bank_idle[b]       = (state_q == BANK_IDLE) ||
                                (state_q == BANK_PRECHARGING && timer_q == '0);
    assign open_row[b]        = row_q;

    // Timer countdown, then ACT/PRE overrides for commands aimed at this bank.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      row_d   = row_q;
      case (state_q)
        BANK_ACTIVATING: begin
          if (timer_q == '0) state_d = BANK_ACTIVE;
          else               timer_d = timer_q - TW'(1);
        end
        BANK_PRECHARGING: begin
          if (timer_q == '0) state_d = BANK_IDLE;
          else               timer_d = timer_q - TW'(1);
        end
        default: ;
      endcase
      if (act_go[b]) begin
        state_d = BANK_ACTIVATING;
        timer_d = TW'(T_RCD - 1);
        row_d   = phy_addr[ROW_WIDTH-1:0];
      end else if (pre_go[b] && state_q == BANK_ACTIVE) begin
        state_d = BANK_PRECHARGING;
        timer_d = TW'(T_RP - 1);
      end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= BANK_IDLE;
        timer_q <= '0;
        row_q   <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        row_q   <= row_d;
      end
    end
  end

  // Command decode: legality against bank state, buffer push and error select.
  always_comb begin
    sampled = !phy_cs_n && (phy_cmd != CMD_NOP);
    act_mis = sampled && ((phy_cmd == CMD_ACT) == phy_act_n);
    cmd_ok  = sampled && !act_mis;
    err_hit = 1'b0;
    err_sel = ERR_NONE;
    act_go  = '0;
    pre_go  = '0;
    push    = 1'b0;
    ref_hit = 1'b0;
    if (act_mis) begin
      err_hit = 1'b1;
      err_sel = ERR_ACT_N;
    end else if (cmd_ok) begin
      case (phy_cmd)
        CMD_ACT: begin
          if (bank_idle[cmd_bank]) begin
            act_go[cmd_bank] = 1'b1;
          end else begin
            err_hit = 1'b1;
            err_sel = ERR_ACT_BUSY;
          end
        end
        CMD_RD, CMD_WR: begin
          if (!bank_rw_ok[cmd_bank]) begin
            err_hit = 1'b1;
            err_sel = ERR_NOT_OPEN;
          end else if (fifo_full && !fifo_pop) begin
            err_hit = 1'b1;
            err_sel = ERR_OVERFLOW;
          end else begin
            push = 1'b1;
          end
        end
        CMD_PRE: begin
          if (phy_addr[10]) begin
            if (|bank_activating) begin
              err_hit = 1'b1;
              err_sel = ERR_PRE_TRCD;
            end else begin
              pre_go = '1;
            end
          end else if (bank_activating[cmd_bank]) begin
            err_hit = 1'b1;
            err_sel = ERR_PRE_TRCD;
          end else begin
            pre_go[cmd_bank] = 1'b1;
          end
        end
        CMD_REF, CMD_MRS, CMD_ZQ: begin
          if (!(&bank_idle)) begin
            err_hit = 1'b1;
            err_sel = ERR_ALL_BUSY;
          end else begin
            ref_hit = (phy_cmd == CMD_REF);
          end
        end
        default: ;
      endcase
    end
  end

  assign push_data = {(phy_cmd == CMD_WR), open_row[cmd_bank], cmd_bank,
                      phy_addr[COL_WIDTH-1:0]};

  rx_txn_fifo #(
    .WIDTH(ADDR_WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_data_i(push_data),
    .full_o     (fifo_full),
    .valid_o    (txn_valid),
    .ready_i    (txn_ready),
    .data_o     (head_data)
  );

  assign txn_write = head_data[ADDR_WIDTH];
  assign txn_addr  = head_data[ADDR_WIDTH-1:0];

  // Error pulse, sticky error code and REF counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      ref_count_q <= 16'd0;
    end else begin
      err_valid_q <= err_hit;
      if (err_hit) err_code_q <= err_sel;
      if (ref_hit) ref_count_q <= ref_count_q + 16'd1;
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign ref_count = ref_count_q;

endmodule

// File: tb/tb_ddr_cmd_receiver.sv
// Directed bench for ddr_cmd_receiver with a transaction scoreboard.
module tb_ddr_cmd_receiver;
  import ddr_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  phy_cmd = CMD_NOP;
  logic [15:0] phy_addr = '0;
  logic [1:0]  phy_bank = '0;
  logic        phy_bg = 1'b0;
  logic        phy_act_n = 1'b1;
  logic        phy_cs_n = 1'b1;
  logic        txn_valid;
  logic        txn_ready = 1'b1;
  logic        txn_write;
  logic [28:0] txn_addr;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] ref_count;

  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];

  ddr_cmd_receiver dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .phy_cmd  (phy_cmd),
    .phy_addr (phy_addr),
    .phy_bank (phy_bank),
    .phy_bg   (phy_bg),
    .phy_act_n(phy_act_n),
    .phy_cs_n (phy_cs_n),
    .txn_valid(txn_valid),
    .txn_ready(txn_ready),
    .txn_write(txn_write),
    .txn_addr (txn_addr),
    .err_valid(err_valid),
    .err_code (err_code),
    .ref_count(ref_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [29:0] mk(input logic w, input logic [15:0] row,
                                     input logic [2:0] bank, input logic [9:0] col);
    return {w, row, bank, col};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: pop/compare the head if a handshake happens at the coming edge.
  task automatic step();
    @(negedge clk);
    if (reset_n && txn_valid && txn_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_txn: observed %0h expected none", {txn_write, txn_addr});
      end
      if (exp_q.size() != 0) chk("txn_pop", {2'b00, txn_write, txn_addr}, {2'b00, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] b, input logic [15:0] a,
                       input logic act_n, input logic cs_n);
    phy_cmd   = c;
    phy_bg    = b[2];
    phy_bank  = b[1:0];
    phy_addr  = a;
    phy_act_n = act_n;
    phy_cs_n  = cs_n;
    step();
    phy_cmd   = CMD_NOP;
    phy_act_n = 1'b1;
    phy_cs_n  = 1'b1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [15:0] a);
    drive(c, b, a, (c != CMD_ACT), 1'b0);
  endtask

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txn_valid", {31'd0, txn_valid}, 32'd0);
    chk("rst_txn_write", {31'd0, txn_write}, 32'd0);
    chk("rst_txn_addr", {3'd0, txn_addr}, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
    chk("rst_err_code", {29'd0, err_code}, 32'd0);
    chk("rst_ref_count", {16'd0, ref_count}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ACT bank 5 row 0x1234, RD col 0x3F four cycles later
    issue(CMD_ACT, 3'd5, 16'h1234);
    idle(3);
    exp_q.push_back(mk(1'b0, 16'h1234, 3'd5, 10'h03F));
    issue(CMD_RD, 3'd5, 16'h003F);
    chk("rd_latency_valid", {31'd0, txn_valid}, 32'd1);
    chk("rd_no_err", {31'd0, err_valid}, 32'd0);
    step();
    chk("rd_drained", {31'd0, txn_valid}, 32'd0);

    // tRCD boundary on bank 2
    issue(CMD_ACT, 3'd2, 16'h00AA);
    idle(2);
    issue(CMD_WR, 3'd2, 16'h0010);
    chk("wr_early_err_valid", {31'd0, err_valid}, 32'd1);
    chk("wr_early_err_code", {29'd0, err_code}, {29'd0, ERR_NOT_OPEN});
    chk("wr_early_no_txn", {31'd0, txn_valid}, 32'd0);
    exp_q.push_back(mk(1'b1, 16'h00AA, 3'd2, 10'h010));
    issue(CMD_WR, 3'd2, 16'h0010);
    chk("wr_ok_no_err", {31'd0, err_valid}, 32'd0);
    chk("wr_ok_code_held", {29'd0, err_code}, {29'd0, ERR_NOT_OPEN});
    chk("wr_ok_valid", {31'd0, txn_valid}, 32'd1);
    step();

    // Overflow with consumer stalled, then push+pop while full
    txn_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 16'h1234, 3'd5, 10'h001));
    issue(CMD_RD, 3'd5, 16'h0001);
    exp_q.push_back(mk(1'b0, 16'h1234, 3'd5, 10'h002));
    issue(CMD_RD, 3'd5, 16'h0002);
    issue(CMD_RD, 3'd5, 16'h0003);
    chk("ovf_err_valid", {31'd0, err_valid}, 32'd1);
    chk("ovf_err_code", {29'd0, err_code}, {29'd0, ERR_OVERFLOW});
    chk("ovf_head_stable", {2'b00, txn_write, txn_addr}, {2'b00, mk(1'b0, 16'h1234, 3'd5, 10'h001)});
    txn_ready = 1'b1;
    exp_q.push_back(mk(1'b0, 16'h1234, 3'd5, 10'h004));
    issue(CMD_RD, 3'd5, 16'h0004);
    chk("full_pushpop_no_err", {31'd0, err_valid}, 32'd0);
    idle(3);
    chk("drain_empty", {31'd0, txn_valid}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);

    // PRE-all during tRCD, then PRE-all and REF at tRP
    issue(CMD_ACT, 3'd1, 16'h0777);
    issue(CMD_PRE, 3'd0, 16'h0400);
    chk("preall_err_code", {29'd0, err_code}, {29'd0, ERR_PRE_TRCD});
    exp_q.push_back(mk(1'b0, 16'h1234, 3'd5, 10'h005));
    issue(CMD_RD, 3'd5, 16'h0005);
    chk("preall_bank5_open", {31'd0, err_valid}, 32'd0);
    issue(CMD_RD, 3'd1, 16'h0006);
    chk("preall_bank1_activating", {29'd0, err_code}, {29'd0, ERR_NOT_OPEN});
    idle(1);
    issue(CMD_PRE, 3'd0, 16'h0400);
    chk("preall_ok", {31'd0, err_valid}, 32'd0);
    idle(2);
    issue(CMD_REF, 3'd0, 16'h0000);
    chk("ref_early_err", {29'd0, err_code}, {29'd0, ERR_ALL_BUSY});
    chk("ref_early_count", {16'd0, ref_count}, 32'd0);
    issue(CMD_REF, 3'd0, 16'h0000);
    chk("ref_ok_no_err", {31'd0, err_valid}, 32'd0);
    chk("ref_ok_count", {16'd0, ref_count}, 32'd1);

    // act_n mismatch, chip-select gating, ACT on a busy bank
    drive(CMD_RD, 3'd0, 16'h0000, 1'b0, 1'b0);
    chk("actn_err_valid", {31'd0, err_valid}, 32'd1);
    chk("actn_err_code", {29'd0, err_code}, {29'd0, ERR_ACT_N});
    drive(CMD_ACT, 3'd3, 16'h0042, 1'b0, 1'b1);
    chk("cs_ignored", {31'd0, err_valid}, 32'd0);
    idle(4);
    issue(CMD_RD, 3'd3, 16'h0000);
    chk("cs_bank3_idle", {29'd0, err_code}, {29'd0, ERR_NOT_OPEN});
    issue(CMD_ACT, 3'd3, 16'h0042);
    issue(CMD_ACT, 3'd3, 16'h0043);
    chk("act_busy_err", {29'd0, err_code}, {29'd0, ERR_ACT_BUSY});
    idle(3);

    // Reset with buffered transactions and an activating bank
    txn_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 16'h0042, 3'd3, 10'h007));
    issue(CMD_RD, 3'd3, 16'h0007);
    exp_q.push_back(mk(1'b0, 16'h0042, 3'd3, 10'h008));
    issue(CMD_RD, 3'd3, 16'h0008);
    issue(CMD_ACT, 3'd0, 16'h0100);
    chk("pre_rst_valid", {31'd0, txn_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, txn_valid}, 32'd0);
    chk("rst_mid_refcnt", {16'd0, ref_count}, 32'd0);
    chk("rst_mid_errcode", {29'd0, err_code}, 32'd0);
    exp_q.delete();
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    txn_ready = 1'b1;
    issue(CMD_RD, 3'd3, 16'h0000);
    chk("post_rst_rd_err", {29'd0, err_code}, {29'd0, ERR_NOT_OPEN});
    issue(CMD_ACT, 3'd0, 16'h0100);
    chk("post_rst_bank0_idle", {31'd0, err_valid}, 32'd0);
    idle(2);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
